// File: rtl/flatten_pkg.sv
// Shared constants, state type and slot helper for the flatten buffer.
package flatten_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int NUM_WORDS  = 400;
  localparam int COUNT_W    = 9;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } flatten_state_t;

  // Bit offset of word slot idx inside the flat output vector.
  function automatic int slot_lsb(input int idx);
    return idx * DATA_WIDTH;
  endfunction

endpackage

// File: rtl/flatten_buffer.sv
// Serial-to-parallel collector feeding the fully-connected classifier.
// Words are written into a register array at slot fill_level; once
// NUM_WORDS words are in, the whole array is published as out_vec and
// held frozen until the classifier takes it.
//
// Handshakes: a transfer happens on a rising clk edge where valid and
// ready are both 1. in_ready depends only on state, never on in_valid;
// out_valid depends only on state, never on out_ready.
//
// Build option: define FLATTEN_LAST_CHECK_EN to check in_last framing
// (err_short / err_long). Without it in_last is ignored and both error
// outputs are constant 0.
module flatten_buffer
  import flatten_pkg::*;
(
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            clear,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_WIDTH-1:0]           in_data,
  input  logic                            in_last,
  output logic [DATA_WIDTH*NUM_WORDS-1:0] out_vec,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [COUNT_W-1:0]              fill_level,
  output logic                            err_short,
  output logic                            err_long
);

  flatten_state_t        state_q, state_d;
  logic [COUNT_W-1:0]    fill_level_q, fill_level_d;
  logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];
  logic [DATA_WIDTH-1:0] mem_d [NUM_WORDS];
  logic                  err_short_q, err_short_d;
  logic                  err_long_q, err_long_d;

  logic accept;
  logic last_slot;
  logic short_abort;
  logic missing_last;

  assign in_ready  = (state_q == FILL);
  assign out_valid = (state_q == FULL);
  assign accept    = in_valid && in_ready;
  assign last_slot = (fill_level_q == COUNT_W'(NUM_WORDS - 1));

`ifdef FLATTEN_LAST_CHECK_EN
  // Early in_last aborts the frame; a final word without in_last is flagged.
  assign short_abort  = in_last && !last_slot;
  assign missing_last = !in_last;
`else
  logic unused_in_last;
  assign unused_in_last = in_last;
  assign short_abort    = 1'b0;
  assign missing_last   = 1'b0;
`endif

  // Next-state, fill counter, slot write and error pulses; clear has priority.
  always_comb begin
    state_d      = state_q;
    fill_level_d = fill_level_q;
    mem_d        = mem_q;
    err_short_d  = 1'b0;
    err_long_d   = 1'b0;
    if (clear) begin
      state_d      = FILL;
      fill_level_d = '0;
    end else begin
      unique case (state_q)
        FILL: begin
          if (accept) begin
            if (short_abort) begin
              err_short_d  = 1'b1;
              fill_level_d = '0;
            end else begin
              mem_d[fill_level_q] = in_data;
              if (last_slot) begin
                state_d      = FULL;
                fill_level_d = '0;
                err_long_d   = missing_last;
              end else begin
                fill_level_d = fill_level_q + COUNT_W'(1);
              end
            end
          end
        end
        FULL: begin
          if (out_ready) begin
            state_d = FILL;
          end
        end
        default: begin
          state_d = FILL;
        end
      endcase
    end
  end

  // State, counter, storage and error registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= FILL;
      fill_level_q <= '0;
      err_short_q  <= 1'b0;
      err_long_q   <= 1'b0;
      for (int i = 0; i < NUM_WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      fill_level_q <= fill_level_d;
      err_short_q  <= err_short_d;
      err_long_q   <= err_long_d;
      mem_q        <= mem_d;
    end
  end

  // Flatten the slot array: word k lands at bits [DATA_WIDTH*k +: DATA_WIDTH].
  for (genvar k = 0; k < NUM_WORDS; k++) begin : g_flat
    assign out_vec[slot_lsb(k) +: DATA_WIDTH] = mem_q[k];
  end

  assign fill_level = fill_level_q;
  assign err_short  = err_short_q;
  assign err_long   = err_long_q;

endmodule
